sdr_ch3_arbiter: RTL and testbench

// - Shares SDRAM channel 3 between the ROM loader and the F2 CPU bus with a proper one-at-a-time arbiter,

---
 rtl/sdr_arb_pkg.sv | 32 +++
 rtl/sdr_arb_port.sv | 34 +++
 rtl/sdr_ch3_arbiter.sv | 148 ++++++++++++++
 tb/tb_sdr_ch3_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sdr_arb_pkg.sv
// Shared types and default widths for the SDRAM channel 3 arbiter.
// Imported by sdr_arb_port and sdr_ch3_arbiter.
package sdr_arb_pkg;

    localparam int SDR_ADDR_W = 27;
    localparam int SDR_DATA_W = 16;
    localparam int SDR_Q_W    = 64;

    typedef enum logic [1:0] {
        FLUSH,
        IDLE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        PORT_ROM,
        PORT_CPU
    } arb_port_t;

    typedef struct packed {
        logic [SDR_ADDR_W-1:0] addr;
        logic [SDR_DATA_W-1:0] din;
        logic [1:0]            be;
        logic                  rnw;
    } sdr_req_t;

    function automatic arb_port_t other_port(input arb_port_t p);
        return (p == PORT_ROM) ? PORT_CPU : PORT_ROM;
    endfunction

endpackage

// File: rtl/sdr_arb_port.sv
// One requester side of the ch3 arbiter: owns the ack toggle, reports pending
// (req != ack) and packs the request fields for the issue mux.
module sdr_arb_port
    import sdr_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic [SDR_ADDR_W-1:0] addr,
    input  logic [SDR_DATA_W-1:0] din,
    input  logic [1:0]            be,
    input  logic                  rnw,
    input  logic                  done,
    output logic                  ack,
    output logic                  pending,
    output sdr_req_t              fields
);

    // NOTE: state in always_ff uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack <= 1'b0;
        end else if (done) begin
            ack <= ~ack;
        end
    end

    assign pending     = req ^ ack;
    assign fields.addr = addr;
    assign fields.din  = din;
    assign fields.be   = be;
    assign fields.rnw  = rnw;

endmodule

// File: rtl/sdr_ch3_arbiter.sv
// One-at-a-time toggle-handshake arbiter sharing SDRAM ch3 between ROM loader and CPU.
// Define SDR_ARB_RR_EN for alternating grants; otherwise fixed priority ROM > CPU.
module sdr_ch3_arbiter
    import sdr_arb_pkg::*;
#(
    parameter int ADDR_W = SDR_ADDR_W,
    parameter int DATA_W = SDR_DATA_W,
    parameter int Q_W    = SDR_Q_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              excl_rom,

    input  logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_din,
    input  logic [1:0]        rom_be,
    input  logic              rom_rnw,
    input  logic              rom_req,
    output logic              rom_ack,

    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    input  logic [1:0]        cpu_be,
    input  logic              cpu_rnw,
    input  logic              cpu_req,
    output logic              cpu_ack,
    output logic [Q_W-1:0]    cpu_q,

    output logic [ADDR_W-1:0] ch3_addr,
    output logic [DATA_W-1:0] ch3_din,
    output logic [1:0]        ch3_be,
    output logic              ch3_rnw,
    output logic              ch3_req,
    input  logic              ch3_ack,
    input  logic [Q_W-1:0]    ch3_dout,

    output logic              busy
);

    arb_state_t state, state_nx;
    arb_port_t  grant, pick;
    sdr_req_t   rom_fields, cpu_fields, sel;
    logic       rom_pend, cpu_pend, rom_elig, cpu_elig;
    logic       issue, ch3_idle, done, rom_done, cpu_done;
`ifdef SDR_ARB_RR_EN
    arb_port_t  rr_last;
`endif

    sdr_arb_port u_rom (
        .clk     (clk),
        .reset   (reset),
        .req     (rom_req),
        .addr    (rom_addr),
        .din     (rom_din),
        .be      (rom_be),
        .rnw     (rom_rnw),
        .done    (rom_done),
        .ack     (rom_ack),
        .pending (rom_pend),
        .fields  (rom_fields)
    );

    sdr_arb_port u_cpu (
        .clk     (clk),
        .reset   (reset),
        .req     (cpu_req),
        .addr    (cpu_addr),
        .din     (cpu_din),
        .be      (cpu_be),
        .rnw     (cpu_rnw),
        .done    (cpu_done),
        .ack     (cpu_ack),
        .pending (cpu_pend),
        .fields  (cpu_fields)
    );

    assign rom_elig = rom_pend;
    assign cpu_elig = cpu_pend & ~excl_rom;
    assign ch3_idle = (ch3_ack == ch3_req);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        pick     = PORT_ROM;
        issue    = 1'b0;
        case (state)
            FLUSH: if (ch3_idle) state_nx = IDLE;
            IDLE: begin
                if (rom_elig && cpu_elig) begin
`ifdef SDR_ARB_RR_EN
                    pick = other_port(rr_last);
`else
                    pick = PORT_ROM;
`endif
                end else if (cpu_elig) begin
                    pick = PORT_CPU;
                end
                if ((rom_elig || cpu_elig) && !reset) begin
                    issue    = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT:    if (ch3_idle) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = FLUSH;
        endcase
    end

    // Completion is recorded on the WAIT->RESP edge so the requester ack moves one cycle after ch3_ack.
    assign done     = (state == WAIT) && ch3_idle && !reset;
    assign rom_done = done && (grant == PORT_ROM);
    assign cpu_done = done && (grant == PORT_CPU);
    assign sel      = (pick == PORT_CPU) ? cpu_fields : rom_fields;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FLUSH;
            grant <= PORT_ROM;
            cpu_q <= '0;
`ifdef SDR_ARB_RR_EN
            rr_last <= PORT_CPU;
`endif
        end else begin
            state <= state_nx;
            if (issue) begin
                grant <= pick;
`ifdef SDR_ARB_RR_EN
                rr_last <= pick;
`endif
            end
            if (cpu_done) cpu_q <= ch3_dout;
        end
    end

    // NOTE: the ch3 request registers are deliberately not reset; ch3_req must keep its toggle
    // phase across reset so FLUSH can drain an operation the SDRAM controller already accepted.
    always_ff @(posedge clk) begin
        if (issue) begin
            ch3_addr <= sel.addr;
            ch3_din  <= sel.din;
            ch3_be   <= sel.be;
            ch3_rnw  <= sel.rnw;
            ch3_req  <= ~ch3_req;
        end
    end

endmodule

// File: tb/tb_sdr_ch3_arbiter.sv
// Directed self-checking bench for sdr_ch3_arbiter (fixed priority by default,
// alternating expectations when SDR_ARB_RR_EN is defined).
module tb_sdr_ch3_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        excl_rom;
    logic [26:0] rom_addr, cpu_addr, ch3_addr;
    logic [15:0] rom_din, cpu_din, ch3_din;
    logic [1:0]  rom_be, cpu_be, ch3_be;
    logic        rom_rnw, cpu_rnw, ch3_rnw;
    logic        rom_req, cpu_req, ch3_req;
    logic        rom_ack, cpu_ack, ch3_ack;
    logic [63:0] cpu_q, ch3_dout;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic        exp_ch3_req = 1'b0;
    logic        exp_rom_ack = 1'b0;
    logic        exp_cpu_ack = 1'b0;
    logic [63:0] exp_cpu_q   = 64'h0;
    logic        is_cpu;
    int          rom_n, cpu_n;

    sdr_ch3_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .excl_rom (excl_rom),
        .rom_addr (rom_addr),
        .rom_din  (rom_din),
        .rom_be   (rom_be),
        .rom_rnw  (rom_rnw),
        .rom_req  (rom_req),
        .rom_ack  (rom_ack),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_be   (cpu_be),
        .cpu_rnw  (cpu_rnw),
        .cpu_req  (cpu_req),
        .cpu_ack  (cpu_ack),
        .cpu_q    (cpu_q),
        .ch3_addr (ch3_addr),
        .ch3_din  (ch3_din),
        .ch3_be   (ch3_be),
        .ch3_rnw  (ch3_rnw),
        .ch3_req  (ch3_req),
        .ch3_ack  (ch3_ack),
        .ch3_dout (ch3_dout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called in an IDLE cycle where the request is already pending; returns in the next IDLE cycle.
    task automatic serve(input logic is_c, input logic [26:0] a, input logic [15:0] d,
                         input logic [1:0] b, input logic rw, input int lat,
                         input logic [63:0] q, input string tag);
        tick();
        exp_ch3_req = ~exp_ch3_req;
        check({tag, " issue"}, 64'({ch3_req, ch3_addr, ch3_din, ch3_be, ch3_rnw}),
              64'({exp_ch3_req, a, d, b, rw}));
        check({tag, " busy_wait"}, 64'(busy), 64'(1'b1));
        for (int i = 0; i < lat; i++) begin
            tick();
            check({tag, " stable"}, 64'({ch3_req, ch3_addr, ch3_din, ch3_be, ch3_rnw, busy}),
                  64'({exp_ch3_req, a, d, b, rw, 1'b1}));
        end
        ch3_ack  = exp_ch3_req;
        ch3_dout = q;
        check({tag, " acks_before"}, 64'({rom_ack, cpu_ack}), 64'({exp_rom_ack, exp_cpu_ack}));
        tick();
        if (is_c) begin
            exp_cpu_ack = ~exp_cpu_ack;
            exp_cpu_q   = q;
        end else begin
            exp_rom_ack = ~exp_rom_ack;
        end
        check({tag, " acks_resp"}, 64'({rom_ack, cpu_ack}), 64'({exp_rom_ack, exp_cpu_ack}));
        check({tag, " cpu_q"}, cpu_q, exp_cpu_q);
        check({tag, " busy_resp"}, 64'(busy), 64'(1'b1));
        ch3_dout = ~q;
        tick();
        check({tag, " busy_idle"}, 64'(busy), 64'(1'b0));
        check({tag, " cpu_q_hold"}, cpu_q, exp_cpu_q);
    endtask

    initial begin
        reset    = 1'b1;
        excl_rom = 1'b0;
        rom_addr = '0; rom_din = '0; rom_be = '0; rom_rnw = 1'b0; rom_req = 1'b0;
        cpu_addr = '0; cpu_din = '0; cpu_be = '0; cpu_rnw = 1'b0; cpu_req = 1'b0;
        ch3_ack  = 1'b0;
        ch3_dout = '0;

        // Reset state and release into IDLE after one FLUSH cycle.
        repeat (3) tick();
        check("reset busy", 64'(busy), 64'(1'b1));
        check("reset acks", 64'({rom_ack, cpu_ack}), 64'(2'b00));
        check("reset cpu_q", cpu_q, 64'h0);
        reset = 1'b0;
        check("flush busy", 64'(busy), 64'(1'b1));
        tick();
        check("idle busy", 64'(busy), 64'(1'b0));
        check("idle ch3_req", 64'(ch3_req), 64'(exp_ch3_req));
        tick();
        check("idle no_issue", 64'({ch3_req, busy}), 64'({exp_ch3_req, 1'b0}));

        // CPU read, ch3 completes three cycles after issue.
        cpu_addr = 27'h0100000; cpu_din = 16'h0000; cpu_be = 2'b11; cpu_rnw = 1'b1;
        cpu_req  = ~cpu_req;
        serve(1'b1, 27'h0100000, 16'h0000, 2'b11, 1'b1, 3, 64'h1122334455667788, "cpu_read");

        // excl_rom: ROM writes only, CPU held with no ack.
        excl_rom = 1'b1;
        cpu_addr = 27'h0200040; cpu_din = 16'hbeef; cpu_be = 2'b01; cpu_rnw = 1'b0;
        cpu_req  = ~cpu_req;
        rom_addr = 27'h0000100; rom_din = 16'h0001; rom_be = 2'b11; rom_rnw = 1'b0;
        rom_req  = ~rom_req;
        for (int i = 0; i < 3; i++) begin
            serve(1'b0, rom_addr, rom_din, 2'b11, 1'b0, 1, 64'hdead_0000_0000_0000, "rom_excl");
            rom_addr = rom_addr + 27'd2;
            rom_din  = rom_din + 16'd1;
            if (i < 2) rom_req = ~rom_req;
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            check("cpu_held", 64'({busy, cpu_ack, ch3_req}), 64'({1'b0, exp_cpu_ack, exp_ch3_req}));
        end
        excl_rom = 1'b0;
        serve(1'b1, 27'h0200040, 16'hbeef, 2'b01, 1'b0, 2, 64'hcafe_f00d_0000_0001, "cpu_after_excl");

        // Both ports pending continuously, four operations each.
        rom_addr = 27'h0001000; rom_din = 16'h1000; rom_be = 2'b11; rom_rnw = 1'b0;
        cpu_addr = 27'h0300000; cpu_din = 16'h2000; cpu_be = 2'b10; cpu_rnw = 1'b1;
        rom_req  = ~rom_req;
        cpu_req  = ~cpu_req;
        rom_n    = 0;
        cpu_n    = 0;
        for (int i = 0; i < 8; i++) begin
`ifdef SDR_ARB_RR_EN
            is_cpu = ((i % 2) == 1);
`else
            is_cpu = (i >= 4);
`endif
            if (is_cpu) begin
                serve(1'b1, cpu_addr, cpu_din, 2'b10, 1'b1, 1,
                      64'h5555_0000_0000_0000 + 64'(i), "prio_cpu");
                cpu_n++;
                cpu_addr = cpu_addr + 27'd8;
                if (cpu_n < 4) cpu_req = ~cpu_req;
            end else begin
                serve(1'b0, rom_addr, rom_din, 2'b11, 1'b0, 1, 64'h0, "prio_rom");
                rom_n++;
                rom_addr = rom_addr + 27'd2;
                rom_din  = rom_din + 16'd1;
                if (rom_n < 4) rom_req = ~rom_req;
            end
        end

        // Reset while a CPU read is in WAIT: acks clear, ch3_req held, FLUSH drains.
        cpu_addr = 27'h0400000; cpu_rnw = 1'b1;
        cpu_req  = ~cpu_req;
        tick();
        exp_ch3_req = ~exp_ch3_req;
        check("rst_wait issue", 64'(ch3_req), 64'(exp_ch3_req));
        reset   = 1'b1;
        rom_req = 1'b0;
        cpu_req = 1'b0;
        tick();
        exp_rom_ack = 1'b0;
        exp_cpu_ack = 1'b0;
        exp_cpu_q   = 64'h0;
        check("rst_wait acks", 64'({rom_ack, cpu_ack}), 64'(2'b00));
        check("rst_wait cpu_q", cpu_q, exp_cpu_q);
        check("rst_wait busy", 64'(busy), 64'(1'b1));
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("flush hold", 64'({busy, ch3_req, rom_ack, cpu_ack}),
                  64'({1'b1, exp_ch3_req, 2'b00}));
        end
        ch3_ack = exp_ch3_req;
        tick();
        check("flush done", 64'({busy, ch3_req, rom_ack, cpu_ack}), 64'({1'b0, exp_ch3_req, 2'b00}));
        tick();
        check("flush no_issue", 64'({busy, ch3_req}), 64'({1'b0, exp_ch3_req}));

        // ROM read after flush: rnw forwarded, cpu_q untouched.
        rom_addr = 27'h7fffffe; rom_din = 16'h00aa; rom_be = 2'b10; rom_rnw = 1'b1;
        rom_req  = ~rom_req;
        serve(1'b0, 27'h7fffffe, 16'h00aa, 2'b10, 1'b1, 1, 64'h0123_4567_89ab_cdef, "rom_read");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
